// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one fixed-latency ALU between two requesters.
// Build option ALU_ARB_OPCHECK_EN: unknown opcodes are answered with resp_err instead of being issued.
module alu_arbiter #(
   parameter int WIDTH   = 32,
   parameter int ALU_LAT = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req0_valid,
   input  logic             req1_valid,
   output logic             req0_ready,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [3:0]       req0_op,
   input  logic [3:0]       req1_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_op,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic             resp_id,
   output logic [WIDTH-1:0] resp_result,
   output logic             resp_zero,
   output logic             resp_err,
   output logic             busy
);

   // state | meaning
   // IDLE  | waiting for a request; the only state that asserts a ready
   // EXEC  | latched operands presented to the ALU for ALU_LAT cycles
   // RESP  | response held stable until the consumer takes it
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] LAT_LOAD = 4'(ALU_LAT - 1);

   state_t           state;
   state_t           state_nxt;
   logic             grant;
   logic             pick1;
   logic             gnt_bad;
   logic             rr_last;
   logic [3:0]       lat_cnt;
   logic [WIDTH-1:0] gnt_a;
   logic [WIDTH-1:0] gnt_b;
   logic [3:0]       gnt_op;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [3:0]       op_q;
   logic             in_exec;

   // rr_last holds the most recent winner, so the other side wins a tie
   assign pick1  = (req0_valid && req1_valid) ? ~rr_last : req1_valid;
   assign gnt_a  = pick1 ? req1_a  : req0_a;
   assign gnt_b  = pick1 ? req1_b  : req0_b;
   assign gnt_op = pick1 ? req1_op : req0_op;

`ifdef ALU_ARB_OPCHECK_EN
   function automatic logic op_known(input logic [3:0] op);
      case (op)
         4'b0010, 4'b0111, 4'b1010, 4'b0110, 4'b0100,
         4'b1001, 4'b0101, 4'b1100, 4'b1101: op_known = 1'b1;
         default:                            op_known = 1'b0;
      endcase
   endfunction

   logic err_q;

   assign gnt_bad  = ~op_known(gnt_op);
   assign resp_err = err_q;
`else
   assign gnt_bad  = 1'b0;
   assign resp_err = 1'b0;
`endif

   always_comb begin
      state_nxt  = state;
      grant      = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (state)
         IDLE: begin
            if (!reset && (req0_valid || req1_valid)) begin
               grant     = 1'b1;
               state_nxt = gnt_bad ? RESP : EXEC;
            end
         end
         EXEC: begin
            if (lat_cnt == 4'd0) state_nxt = RESP;
         end
         RESP: begin
            if (resp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      req0_ready = grant && !pick1;
      req1_ready = grant &&  pick1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         rr_last     <= 1'b1;
         lat_cnt     <= '0;
         op_a        <= '0;
         op_b        <= '0;
         op_q        <= '0;
         resp_id     <= 1'b0;
         resp_result <= '0;
         resp_zero   <= 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
         err_q       <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         if (grant) begin
            rr_last <= pick1;
            resp_id <= pick1;
            lat_cnt <= LAT_LOAD;
            op_a    <= gnt_a;
            op_b    <= gnt_b;
            op_q    <= gnt_op;
`ifdef ALU_ARB_OPCHECK_EN
            err_q   <= gnt_bad;
`endif
            // rejected opcodes go straight to RESP with a cleared payload
            if (gnt_bad) begin
               resp_result <= '0;
               resp_zero   <= 1'b0;
            end
         end
         if (state == EXEC) begin
            if (lat_cnt != 4'd0) begin
               lat_cnt <= lat_cnt - 4'd1;
            end else begin
               resp_result <= alu_result;
               resp_zero   <= alu_zero;
            end
         end
      end
   end

   assign in_exec    = (state == EXEC);
   assign alu_a      = in_exec ? op_a : '0;
   assign alu_b      = in_exec ? op_b : '0;
   assign alu_op     = in_exec ? op_q : 4'b0000;
   assign resp_valid = (state == RESP);
   assign busy       = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: two arbiters (ALU_LAT 1 and 3) with bench-side ALUs, checked every cycle
// against a transaction-timeline model plus directed literal checks.
module tb_alu_arbiter;

   localparam int W = 32;
   localparam logic [3:0] OP_ADD = 4'b0010, OP_SUB = 4'b1010, OP_AND = 4'b0110;
   localparam logic [3:0] OP_XOR = 4'b1001, OP_MOV = 4'b1101;

   logic          clock;
   logic [1:0]    reset, v0, v1, rdy0, rdy1, rv, rr, rid, rz, rerr, bsy, az;
   logic [W-1:0]  a0 [2], b0 [2], a1 [2], b1 [2];
   logic [W-1:0]  alu_a [2], alu_b [2], alu_res [2], rres [2];
   logic [3:0]    op0 [2], op1 [2], alu_op [2];
   logic [W:0]    pipe0, pipe1;
   logic [3:0]    legal_ops [9];

   int n_tests;
   int n_fail;

   // model state: one in-flight transaction per instance, e = cycles since grant
   bit            inflight [2];
   bit            skp [2];
   bit            last [2];
   int            e [2];
   bit            mid [2];
   logic [W-1:0]  ma [2], mb [2], mres [2];
   logic [3:0]    mop [2];
   bit            mz [2], merr [2];
   bit            ex_m, rs_m, gnt_m, gid_m;
   int            lat_m;

   for (genvar k = 0; k < 2; k++) begin : g_dut
      alu_arbiter #(.WIDTH(W), .ALU_LAT(k == 0 ? 1 : 3)) u_dut (
         .clock      (clock),
         .reset      (reset[k]),
         .req0_valid (v0[k]),
         .req1_valid (v1[k]),
         .req0_ready (rdy0[k]),
         .req1_ready (rdy1[k]),
         .req0_a     (a0[k]),
         .req0_b     (b0[k]),
         .req1_a     (a1[k]),
         .req1_b     (b1[k]),
         .req0_op    (op0[k]),
         .req1_op    (op1[k]),
         .alu_a      (alu_a[k]),
         .alu_b      (alu_b[k]),
         .alu_op     (alu_op[k]),
         .alu_result (alu_res[k]),
         .alu_zero   (az[k]),
         .resp_valid (rv[k]),
         .resp_ready (rr[k]),
         .resp_id    (rid[k]),
         .resp_result(rres[k]),
         .resp_zero  (rz[k]),
         .resp_err   (rerr[k]),
         .busy       (bsy[k])
      );
   end

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic logic [W:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [3:0] op);
      logic [W-1:0] r;
      case (op)
         4'b0010: r = a + b;
         4'b1010: r = a - b;
         4'b0110: r = a & b;
         4'b0100: r = a | b;
         4'b1001: r = a ^ b;
         4'b0101: r = ~(a | b);
         4'b1100: r = ~(a & b);
         4'b1101: r = a;
         4'b0111: r = (b == '0) ? a : '0;
         default: r = a ^ b ^ 32'h5A5A_5A5A;
      endcase
      return {(r == '0), r};
   endfunction

   function automatic bit is_legal(input logic [3:0] op);
      return op inside {4'b0010, 4'b0111, 4'b1010, 4'b0110, 4'b0100,
                        4'b1001, 4'b0101, 4'b1100, 4'b1101};
   endfunction

   // bench ALUs: instance 0 is combinational, instance 1 is a two-stage pipe
   always_comb begin
      logic [W:0] f0;
      f0         = alu_f(alu_a[0], alu_b[0], alu_op[0]);
      alu_res[0] = f0[W-1:0];
      az[0]      = f0[W];
      alu_res[1] = pipe1[W-1:0];
      az[1]      = pipe1[W];
   end

   always @(posedge clock) begin
      pipe0 <= alu_f(alu_a[1], alu_b[1], alu_op[1]);
      pipe1 <= pipe0;
   end

   task automatic chk(input string name, input int k, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h at %0t", name, k, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      for (int k = 0; k < 2; k++) begin
         lat_m = (k == 0) ? 1 : 3;
         ex_m  = inflight[k] && !skp[k] && (e[k] <= lat_m);
         rs_m  = inflight[k] && !ex_m;
         gnt_m = !inflight[k] && !reset[k] && (v0[k] || v1[k]);
         gid_m = (v0[k] && v1[k]) ? !last[k] : v1[k];
         chk("req0_ready", k, W'(rdy0[k]), W'(gnt_m && !gid_m));
         chk("req1_ready", k, W'(rdy1[k]), W'(gnt_m && gid_m));
         chk("busy",       k, W'(bsy[k]),  W'(inflight[k]));
         chk("alu_op",     k, W'(alu_op[k]), ex_m ? W'(mop[k]) : '0);
         chk("alu_a",      k, alu_a[k], ex_m ? ma[k] : '0);
         chk("alu_b",      k, alu_b[k], ex_m ? mb[k] : '0);
         chk("resp_valid", k, W'(rv[k]), W'(rs_m));
         if (rs_m) begin
            chk("resp_id",     k, W'(rid[k]),  W'(mid[k]));
            chk("resp_result", k, rres[k],     mres[k]);
            chk("resp_zero",   k, W'(rz[k]),   W'(mz[k]));
            chk("resp_err",    k, W'(rerr[k]), W'(merr[k]));
         end
         if (reset[k]) begin
            inflight[k] = 1'b0;
            last[k]     = 1'b1;
         end else if (inflight[k]) begin
            if (rs_m && rr[k]) inflight[k] = 1'b0;
            else               e[k]++;
         end else if (gnt_m) begin
            inflight[k] = 1'b1;
            e[k]        = 1;
            mid[k]      = gid_m;
            last[k]     = gid_m;
            ma[k]       = gid_m ? a1[k]  : a0[k];
            mb[k]       = gid_m ? b1[k]  : b0[k];
            mop[k]      = gid_m ? op1[k] : op0[k];
`ifdef ALU_ARB_OPCHECK_EN
            skp[k]      = !is_legal(mop[k]);
`else
            skp[k]      = 1'b0;
`endif
            merr[k]     = skp[k];
            {mz[k], mres[k]} = skp[k] ? '0 : alu_f(ma[k], mb[k], mop[k]);
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [3:0] rand_op();
      if ($urandom_range(0, 5) == 0) return 4'($urandom);
      return legal_ops[$urandom_range(0, 8)];
   endfunction

   initial begin
      legal_ops = '{4'b0010, 4'b0111, 4'b1010, 4'b0110, 4'b0100,
                    4'b1001, 4'b0101, 4'b1100, 4'b1101};
      n_tests = 0;
      n_fail  = 0;
      reset = 2'b11; v0 = 2'b11; v1 = 2'b11; rr = 2'b11;
      for (int k = 0; k < 2; k++) begin
         a0[k] = '0; b0[k] = '0; a1[k] = '0; b1[k] = '0;
         op0[k] = OP_ADD; op1[k] = OP_ADD;
         inflight[k] = 1'b0; last[k] = 1'b1; e[k] = 0; skp[k] = 1'b0;
      end

      // reset values, with valids high to prove the readies stay low
      @(negedge clock);
      for (int k = 0; k < 2; k++) begin
         chk("rst_rdy0",  k, W'(rdy0[k]), '0);
         chk("rst_rdy1",  k, W'(rdy1[k]), '0);
         chk("rst_rv",    k, W'(rv[k]),   '0);
         chk("rst_rid",   k, W'(rid[k]),  '0);
         chk("rst_rres",  k, rres[k],     '0);
         chk("rst_rz",    k, W'(rz[k]),   '0);
         chk("rst_rerr",  k, W'(rerr[k]), '0);
         chk("rst_busy",  k, W'(bsy[k]),  '0);
         chk("rst_aluop", k, W'(alu_op[k]), '0);
         chk("rst_alua",  k, alu_a[k],    '0);
      end
      tick();
      reset = 2'b00; v0 = 2'b00; v1 = 2'b00;

      // simultaneous requests straight after reset: 0 then 1
      v0[0] = 1'b1; a0[0] = 10; b0[0] = 5;  op0[0] = OP_SUB;
      v1[0] = 1'b1; a1[0] = 5;  b1[0] = 10; op1[0] = OP_XOR;
      @(negedge clock);
      chk("tie_g0_rdy0", 0, W'(rdy0[0]), 1);
      chk("tie_g0_rdy1", 0, W'(rdy1[0]), 0);
      tick(); v0[0] = 1'b0;
      tick();
      @(negedge clock);
      chk("tie_r0_res", 0, rres[0], 5);
      chk("tie_r0_id",  0, W'(rid[0]), 0);
      tick();
      @(negedge clock);
      chk("tie_g1_rdy1", 0, W'(rdy1[0]), 1);
      tick(); v1[0] = 1'b0;
      tick();
      @(negedge clock);
      chk("tie_r1_res", 0, rres[0], 15);
      chk("tie_r1_id",  0, W'(rid[0]), 1);
      tick();

      // ADD 15+15, back-to-back grants three cycles apart
      v0[0] = 1'b1; a0[0] = 15; b0[0] = 15; op0[0] = OP_ADD;
      @(negedge clock);
      chk("add_rdy", 0, W'(rdy0[0]), 1);
      tick();
      @(negedge clock);
      chk("add_aluop", 0, W'(alu_op[0]), W'(OP_ADD));
      chk("add_rdy_exec", 0, W'(rdy0[0]), 0);
      tick();
      @(negedge clock);
      chk("add_rv",  0, W'(rv[0]), 1);
      chk("add_res", 0, rres[0], 30);
      chk("add_aluop_resp", 0, W'(alu_op[0]), 0);
      tick();
      @(negedge clock);
      chk("add_regrant", 0, W'(rdy0[0]), 1);
      tick(); v0[0] = 1'b0;
      tick();
      tick();

      // consumer stalls for five cycles in RESP
      v1[0] = 1'b1; a1[0] = 32'h0000_FF00; b1[0] = 32'h0000_0F0F; op1[0] = OP_AND; rr[0] = 1'b0;
      tick(); v1[0] = 1'b0; v0[0] = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         chk("stall_rv",   0, W'(rv[0]),   1);
         chk("stall_busy", 0, W'(bsy[0]),  1);
         chk("stall_rdy0", 0, W'(rdy0[0]), 0);
         chk("stall_res",  0, rres[0], 32'h0000_0F00);
         tick();
      end
      rr[0] = 1'b1; v0[0] = 1'b0;
      tick();

      // unknown opcode
      v1[0] = 1'b1; a1[0] = 7; b1[0] = 9; op1[0] = 4'b1111;
      @(negedge clock);
      chk("bad_rdy", 0, W'(rdy1[0]), 1);
      tick(); v1[0] = 1'b0;
      @(negedge clock);
`ifdef ALU_ARB_OPCHECK_EN
      chk("bad_rv",    0, W'(rv[0]),   1);
      chk("bad_err",   0, W'(rerr[0]), 1);
      chk("bad_res",   0, rres[0],     0);
      chk("bad_aluop", 0, W'(alu_op[0]), 0);
`else
      chk("bad_aluop", 0, W'(alu_op[0]), 15);
      chk("bad_rv",    0, W'(rv[0]),   0);
      chk("bad_busy",  0, W'(bsy[0]),  1);
`endif
      tick(); tick(); tick();

      // MOV with ALU_LAT=3
      v0[1] = 1'b1; a0[1] = 32'hDEAD_BEEF; b0[1] = 32'h0001_2345; op0[1] = OP_MOV;
      @(negedge clock);
      chk("mov_rdy", 1, W'(rdy0[1]), 1);
      tick(); v0[1] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk("mov_aluop", 1, W'(alu_op[1]), W'(OP_MOV));
         chk("mov_alua",  1, alu_a[1], 32'hDEAD_BEEF);
         chk("mov_rv",    1, W'(rv[1]), 0);
         tick();
      end
      @(negedge clock);
      chk("mov_rv_resp", 1, W'(rv[1]), 1);
      chk("mov_res",     1, rres[1], 32'hDEAD_BEEF);
      chk("mov_zero",    1, W'(rz[1]), 0);
      tick();

      // reset in the middle of EXEC
      v1[1] = 1'b1; a1[1] = 1; b1[1] = 2; op1[1] = OP_ADD;
      @(negedge clock);
      chk("rx_rdy", 1, W'(rdy1[1]), 1);
      tick(); v1[1] = 1'b0;
      tick(); reset[1] = 1'b1;
      @(negedge clock);
      chk("rx_busy_pre", 1, W'(bsy[1]), 1);
      tick(); reset[1] = 1'b0; v0[1] = 1'b1; v1[1] = 1'b1;
      @(negedge clock);
      chk("rx_rv",    1, W'(rv[1]),   0);
      chk("rx_busy",  1, W'(bsy[1]),  0);
      chk("rx_aluop", 1, W'(alu_op[1]), 0);
      chk("rx_rdy0",  1, W'(rdy0[1]), 1);
      chk("rx_rdy1",  1, W'(rdy1[1]), 0);
      tick(); v0[1] = 1'b0; v1[1] = 1'b0;
      repeat (5) tick();

      // random traffic
      for (int c = 0; c < 4000; c++) begin
         for (int k = 0; k < 2; k++) begin
            v0[k]  = ($urandom_range(0, 2) != 0);
            v1[k]  = ($urandom_range(0, 1) != 0);
            a0[k]  = $urandom;
            b0[k]  = ($urandom_range(0, 3) == 0) ? a0[k] : $urandom;
            a1[k]  = $urandom;
            b1[k]  = ($urandom_range(0, 3) == 0) ? a1[k] : $urandom;
            op0[k] = rand_op();
            op1[k] = rand_op();
            rr[k]  = ($urandom_range(0, 3) != 0);
            reset[k] = ($urandom_range(0, 149) == 0);
         end
         tick();
      end
      reset = 2'b00; v0 = 2'b00; v1 = 2'b00; rr = 2'b11;
      repeat (10) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
